ohs_pwm_axi_master: RTL and testbench

//   AXI4-Lite initiator that drives the PWM level-1 register slave (period @0x0, comparator @0x4,

---
 rtl/ohs_pwm_axi_master.sv | 212 +++++++++++++++++++++
 tb/tb_ohs_pwm_axi_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ohs_pwm_axi_master.sv
// AXI4-Lite initiator for the PWM register slave.
// Converts a single-outstanding command/response port into AXI4-Lite write
// and read transactions. A watchdog aborts any transaction that stalls for
// TIMEOUT cycles, so a dead slave cannot hang the controller.
module ohs_pwm_axi_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_areset,
  // command / response port
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  // write address channel
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  // write data channel
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  // write response channel
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  // read address channel
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  // read data channel
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  // Counter only needs to reach TIMEOUT-1; it saturates at all ones.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_D = 3'd4
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic [ADDR_WIDTH-1:0]   awaddr_n, araddr_n;
  logic [DATA_WIDTH-1:0]   wdata_n;
  logic [STRB_W-1:0]       wstrb_n;
  logic                    rsp_valid_n, rsp_timeout_n;
  logic [DATA_WIDTH-1:0]   rsp_rdata_n;
  logic [1:0]              rsp_resp_n;
  logic                    progress;
  logic                    expired;

  // Commands are only taken in IDLE and never while reset is held.
  assign cmd_ready = (state == IDLE) && !m_axi_areset;

  // Watchdog expiry: the current cycle is the TIMEOUT-th busy cycle (or later).
  assign expired = (TIMEOUT != 0) && (cnt >= CNT_LAST);

  // Next-state and next-output logic; a handshake that moves the FSM on the
  // expiry edge takes precedence over the abort.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    awvalid_n     = m_axi_awvalid;
    wvalid_n      = m_axi_wvalid;
    bready_n      = m_axi_bready;
    arvalid_n     = m_axi_arvalid;
    rready_n      = m_axi_rready;
    awaddr_n      = m_axi_awaddr;
    araddr_n      = m_axi_araddr;
    wdata_n       = m_axi_wdata;
    wstrb_n       = m_axi_wstrb;
    rsp_valid_n   = 1'b0;
    rsp_rdata_n   = rsp_rdata;
    rsp_resp_n    = rsp_resp;
    rsp_timeout_n = rsp_timeout;
    progress      = 1'b0;

    if (state != IDLE && cnt != CNT_MAX) begin
      cnt_n = cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cnt_n = '0;
          if (cmd_write) begin
            awaddr_n  = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_n   = cmd_wdata;
            wstrb_n   = '1;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = WR;
          end else begin
            araddr_n  = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
            arvalid_n = 1'b1;
            state_n   = RD_A;
          end
        end
      end
      WR: begin
        // Each channel drops independently once its own handshake happens.
        awvalid_n = m_axi_awvalid && !m_axi_awready;
        wvalid_n  = m_axi_wvalid && !m_axi_wready;
        if (!awvalid_n && !wvalid_n) begin
          progress = 1'b1;
          bready_n = 1'b1;
          state_n  = WR_B;
        end
      end
      WR_B: begin
        if (m_axi_bvalid) begin
          progress    = 1'b1;
          bready_n    = 1'b0;
          rsp_resp_n  = m_axi_bresp;
          rsp_valid_n = 1'b1;
          state_n     = IDLE;
        end
      end
      RD_A: begin
        if (m_axi_arready) begin
          progress  = 1'b1;
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_D;
        end
      end
      RD_D: begin
        if (m_axi_rvalid) begin
          progress    = 1'b1;
          rready_n    = 1'b0;
          rsp_rdata_n = m_axi_rdata;
          rsp_resp_n  = m_axi_rresp;
          rsp_valid_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (state != IDLE && !progress && expired) begin
      awvalid_n     = 1'b0;
      wvalid_n      = 1'b0;
      bready_n      = 1'b0;
      arvalid_n     = 1'b0;
      rready_n      = 1'b0;
      rsp_valid_n   = 1'b1;
      rsp_resp_n    = 2'b11;
      rsp_timeout_n = 1'b1;
      state_n       = IDLE;
    end
  end

  // State, channel and response registers; reset abandons any transaction.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state         <= IDLE;
      cnt           <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_araddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      rsp_timeout   <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      m_axi_awvalid <= awvalid_n;
      m_axi_wvalid  <= wvalid_n;
      m_axi_bready  <= bready_n;
      m_axi_arvalid <= arvalid_n;
      m_axi_rready  <= rready_n;
      m_axi_awaddr  <= awaddr_n;
      m_axi_araddr  <= araddr_n;
      m_axi_wdata   <= wdata_n;
      m_axi_wstrb   <= wstrb_n;
      rsp_valid     <= rsp_valid_n;
      rsp_rdata     <= rsp_rdata_n;
      rsp_resp      <= rsp_resp_n;
      rsp_timeout   <= rsp_timeout_n;
    end
  end

endmodule

// File: tb/tb_ohs_pwm_axi_master.sv
// Directed testbench for ohs_pwm_axi_master with a delay-configurable
// AXI4-Lite slave model. The watchdog is shortened to 16 cycles.
module tb_ohs_pwm_axi_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  // slave model controls
  logic [15:0] aw_dly, w_dly, ar_dly, b_dly, r_dly;
  logic [1:0]  bresp_val, rresp_val;
  logic [31:0] rdata_val;
  logic [15:0] aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        aw_got, w_got, ar_got;

  int errors = 0;
  int checks = 0;

  // per-transaction observations
  int          lat, aw_n, w_n, ar_n;
  logic        got;
  logic [3:0]  cap_awaddr, cap_araddr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        cap_rdy;

  ohs_pwm_axi_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: each ready rises after the valid has waited <dly> cycles.
  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid  && (w_cnt  >= w_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);
  assign bresp   = bresp_val;
  assign rresp   = rresp_val;
  assign rdata   = rdata_val;

  always @(posedge clk) begin
    aw_cnt <= (rst || !awvalid || awready) ? 16'd0 : aw_cnt + 16'd1;
    w_cnt  <= (rst || !wvalid  || wready)  ? 16'd0 : w_cnt  + 16'd1;
    ar_cnt <= (rst || !arvalid || arready) ? 16'd0 : ar_cnt + 16'd1;
  end

  // Write response: bvalid b_dly cycles after both address and data arrived.
  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; b_cnt <= 16'd0;
    end else if (bvalid && bready) begin
      aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; b_cnt <= 16'd0;
    end else begin
      if (awvalid && awready) aw_got <= 1'b1;
      if (wvalid && wready) w_got <= 1'b1;
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid) begin
        if (b_cnt >= b_dly) bvalid <= 1'b1;
        else b_cnt <= b_cnt + 16'd1;
      end
    end
  end

  // Read data: rvalid r_dly cycles after the address handshake.
  always @(posedge clk) begin
    if (rst) begin
      ar_got <= 1'b0; rvalid <= 1'b0; r_cnt <= 16'd0;
    end else if (rvalid && rready) begin
      ar_got <= 1'b0; rvalid <= 1'b0; r_cnt <= 16'd0;
    end else begin
      if (arvalid && arready) ar_got <= 1'b1;
      if ((ar_got || (arvalid && arready)) && !rvalid) begin
        if (r_cnt >= r_dly) rvalid <= 1'b1;
        else r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and follow it to its response. lat counts the cycles
  // from the accept cycle through the rsp_valid cycle, both included.
  task automatic run_txn(input logic wr, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    got = 1'b0; lat = 0; aw_n = 0; w_n = 0; ar_n = 0; cap_rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin
        cap_awaddr = awaddr; cap_wdata = wdata; cap_wstrb = wstrb; cap_araddr = araddr;
      end
      aw_n = aw_n + int'(awvalid);
      w_n  = w_n  + int'(wvalid);
      ar_n = ar_n + int'(arvalid);
      if (rsp_valid) begin
        got = 1'b1; lat = i + 2; cap_rdy = cmd_ready;
        break;
      end
      @(posedge clk); #1;
    end
    check("rsp_seen", got, 1'b1);
    @(posedge clk); #1;
    check("rsp_single_pulse", rsp_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_wdata = 32'h0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
    bresp_val = 2'b00; rresp_val = 2'b00; rdata_val = 32'h0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_awaddr", awaddr, 4'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_resp", rsp_resp, 2'b00);
    check("rst_rsp_timeout", rsp_timeout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", cmd_ready, 1'b1);

    // zero-wait write 0x0 <= 1000: response three edges after accept (4 cycles inclusive)
    run_txn(1'b1, 4'h0, 32'd1000);
    check("w0_awaddr", cap_awaddr, 4'h0);
    check("w0_wdata", cap_wdata, 32'd1000);
    check("w0_wstrb", cap_wstrb, 4'hF);
    check("w0_latency", lat, 4);
    check("w0_resp", rsp_resp, 2'b00);
    check("w0_aw_cycles", aw_n, 1);
    check("w0_w_cycles", w_n, 1);
    check("w0_cmd_ready_at_rsp", cap_rdy, 1'b1);

    // awready late, wready immediate: wvalid 1 cycle, awvalid 3 cycles
    aw_dly = 2;
    run_txn(1'b1, 4'h4, 32'd250);
    check("w1_aw_cycles", aw_n, 3);
    check("w1_w_cycles", w_n, 1);
    check("w1_awaddr", cap_awaddr, 4'h4);
    check("w1_latency", lat, 6);
    aw_dly = 0;

    // zero-wait read of 0x0
    rdata_val = 32'h0000CAFE;
    run_txn(1'b0, 4'h0, 32'h0);
    check("r0_araddr", cap_araddr, 4'h0);
    check("r0_latency", lat, 4);
    check("r0_rdata", rsp_rdata, 32'h0000CAFE);

    // read 0x8 with rvalid delayed 5 cycles
    rdata_val = 32'h00001234; r_dly = 5;
    run_txn(1'b0, 4'h8, 32'h0);
    check("r1_araddr", cap_araddr, 4'h8);
    check("r1_rdata", rsp_rdata, 32'h00001234);
    check("r1_resp", rsp_resp, 2'b00);
    check("r1_latency", lat, 9);
    check("r1_ar_cycles", ar_n, 1);
    r_dly = 0;

    // unaligned address is forced to a word boundary; slave error passed through
    bresp_val = 2'b10;
    run_txn(1'b1, 4'h7, 32'h55);
    check("w2_awaddr", cap_awaddr, 4'h4);
    check("w2_resp", rsp_resp, 2'b10);
    check("w2_timeout_clear", rsp_timeout, 1'b0);
    bresp_val = 2'b00;

    // stuck arready: watchdog aborts after 16 busy cycles
    ar_dly = 16'hFFFF;
    run_txn(1'b0, 4'h4, 32'h0);
    check("to_ar_cycles", ar_n, 16);
    check("to_latency", lat, 18);
    check("to_resp", rsp_resp, 2'b11);
    check("to_sticky", rsp_timeout, 1'b1);
    check("to_rdata_held", rsp_rdata, 32'h00001234);
    check("to_arvalid_low", arvalid, 1'b0);
    ar_dly = 0;

    // timeout flag stays set across a normal transaction
    run_txn(1'b1, 4'h8, 32'h9);
    check("after_to_resp", rsp_resp, 2'b00);
    check("after_to_sticky", rsp_timeout, 1'b1);

    // reset while waiting in WR_B abandons the write
    b_dly = 16'd1000;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'h77;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("wrb_bready", bready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("wrb_rst_bready", bready, 1'b0);
    check("wrb_rst_cmd_ready", cmd_ready, 1'b0);
    check("wrb_rst_rsp_valid", rsp_valid, 1'b0);
    check("wrb_rst_timeout_cleared", rsp_timeout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    b_dly = 0;
    #1;
    check("wrb_release_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;
    check("wrb_no_rsp", rsp_valid, 1'b0);
    check("wrb_awvalid_idle", awvalid, 1'b0);

    // normal operation after the abandoned transaction
    run_txn(1'b1, 4'h4, 32'd500);
    check("final_resp", rsp_resp, 2'b00);
    check("final_wdata", cap_wdata, 32'd500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
